// File: rtl/priority_event_encoder.sv
// Edge-triggered event capture with a masked highest-index-first grant and
// a registered valid/ack handshake; lost events raise a sticky overrun flag.
module priority_event_encoder #(
  parameter int N_LINES   = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_LINES-1:0]   in_lines,
  input  logic                 mask_we,
  input  logic [N_LINES-1:0]   mask_in,
  input  logic                 out_ack,
  output logic                 out_valid,
  output logic [IDX_WIDTH-1:0] out_index,
  output logic [N_LINES-1:0]   pending,
  output logic                 overrun
);

  if (N_LINES < 2 || N_LINES > 64) begin : g_bad_lines
    $error("priority_event_encoder: N_LINES must be within 2..64");
  end
  if (IDX_WIDTH != $clog2(N_LINES)) begin : g_bad_width
    $error("priority_event_encoder: IDX_WIDTH must equal clog2(N_LINES)");
  end

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  localparam logic [N_LINES-1:0] LP_ONE = {{(N_LINES-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_load;
  logic [IDX_WIDTH-1:0] r_index;
  logic [N_LINES-1:0]   r_pending;
  logic [N_LINES-1:0]   r_mask;
  logic [N_LINES-1:0]   r_in_prev;
  logic                 r_overrun;
  logic [N_LINES-1:0]   w_rise;
  logic [N_LINES-1:0]   w_presented;
  logic [N_LINES-1:0]   w_clear;
  logic [N_LINES-1:0]   w_cand;
  logic [N_LINES-1:0]   w_pending_next;
  logic                 w_lost;

  function automatic logic [IDX_WIDTH-1:0] f_highest(input logic [N_LINES-1:0] vec);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_LINES; i++) begin
      idx = vec[i] ? IDX_WIDTH'(i) : idx;
    end
    return idx;
  endfunction

  assign w_rise         = in_lines & ~r_in_prev;
  assign w_presented    = (r_state == ST_PRESENT) ? (LP_ONE << r_index) : '0;
  assign w_clear        = out_ack ? w_presented : '0;
  assign w_cand         = r_pending & r_mask & ~w_presented;
  // A new rise on the line being acked re-arms it instead of counting as lost.
  assign w_pending_next = (r_pending & ~w_clear) | w_rise;
  assign w_lost         = |(w_rise & r_pending & ~w_clear);

  // Grant FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_cand) begin
          w_state_next = ST_PRESENT;
          w_load       = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (out_ack) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_PRESENT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Grant FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Presented index, captured only when a grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index <= '0;
    end else if (w_load) begin
      r_index <= f_highest(w_cand);
    end else begin
      r_index <= r_index;
    end
  end

  // Event capture, mask and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '1;
      r_in_prev <= '1;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_mask    <= mask_we ? mask_in : r_mask;
      r_in_prev <= in_lines;
      r_overrun <= r_overrun | w_lost;
    end
  end

  assign out_valid = (r_state == ST_PRESENT);
  assign out_index = r_index;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_priority_event_encoder.sv
// Randomized and directed bench for priority_event_encoder (N_LINES=8) with a
// cycle-level behavioural reference model built from the event/grant rules.
module tb_priority_event_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_lines = 8'h00;
  logic       mask_we = 1'b0;
  logic [7:0] mask_in = 8'h00;
  logic       out_ack = 1'b0;
  logic       out_valid;
  logic [2:0] out_index;
  logic [7:0] pending;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_prev, m_pending, m_mask;
  bit         m_valid, m_overrun;
  int         m_index;

  priority_event_encoder #(.N_LINES(8), .IDX_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .in_lines(in_lines), .mask_we(mask_we),
    .mask_in(mask_in), .out_ack(out_ack), .out_valid(out_valid),
    .out_index(out_index), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_prev = 8'hFF; m_pending = 8'h00; m_mask = 8'hFF;
    m_valid = 1'b0; m_index = 0; m_overrun = 1'b0;
  endfunction

  // One rising edge of the reference: events, grant decision, mask, history.
  function automatic void model_edge();
    logic [7:0] np;
    int top;
    int clr;
    clr = (m_valid && out_ack) ? m_index : -1;
    top = -1;
    for (int i = 7; i >= 0; i--)
      if (top < 0 && m_pending[i] && m_mask[i] && !(m_valid && i == m_index)) top = i;
    np = m_pending;
    for (int i = 0; i < 8; i++) begin
      if (in_lines[i] && !m_prev[i]) begin
        if (m_pending[i] && i != clr) m_overrun = 1'b1;
        np[i] = 1'b1;
      end else if (i == clr) begin
        np[i] = 1'b0;
      end
    end
    if (m_valid) begin
      if (out_ack) m_valid = 1'b0;
    end else if (top >= 0) begin
      m_valid = 1'b1;
      m_index = top;
    end
    m_pending = np;
    if (mask_we) m_mask = mask_in;
    m_prev = in_lines;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [7:0] lines, input logic we, input logic [7:0] mask, input logic ack);
    in_lines = lines; mask_we = we; mask_in = mask; out_ack = ack;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mask_we = 1'b0; out_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_index !== 3'd0 || pending !== 8'h00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b idx=%0d pend=%h ovr=%b, expected 0/0/00/0",
               out_valid, out_index, pending, overrun);
    end
    in_lines = 8'h5A;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL reset_held_edge: got v=%b pend=%h, expected v=0 pend=00", out_valid, pending);
    end
    in_lines = 8'h00;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_two_lines();
    logic [7:0] ins  [7] = '{8'h00, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
    logic       acks [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] idx_seen [7];
    logic       v_seen [7];
    apply_reset();
    for (int s = 0; s < 7; s++) begin
      drive(ins[s], 1'b0, 8'h00, acks[s]);
      step();
      v_seen[s] = out_valid; idx_seen[s] = out_index;
      checks++;
      if (out_valid !== m_valid || out_index !== 3'(m_index) || pending !== m_pending || overrun !== m_overrun) begin
        errors++;
        $display("FAIL two_lines step %0d: got v=%b idx=%0d pend=%h ovr=%b, expected v=%b idx=%0d pend=%h ovr=%b",
                 s, out_valid, out_index, pending, overrun, m_valid, m_index, m_pending, m_overrun);
      end
    end
    checks++;
    if (!(v_seen[2] === 1'b1 && idx_seen[2] === 3'd5 && v_seen[3] === 1'b0 &&
          v_seen[4] === 1'b1 && idx_seen[4] === 3'd1 && pending === 8'h00)) begin
      errors++;
      $display("FAIL two_lines_order: got grants %b/%0d idle=%b %b/%0d pend=%h, expected 1/5 idle=0 1/1 pend=00",
               v_seen[2], idx_seen[2], v_seen[3], v_seen[4], idx_seen[4], pending);
    end
  endtask

  task automatic test_mask();
    logic [7:0] ins  [6] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    logic       wes  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] msks [6] = '{8'h7F, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      drive(ins[s], wes[s], msks[s], 1'b0);
      step();
      checks++;
      if (out_valid !== m_valid || out_index !== 3'(m_index) || pending !== m_pending || overrun !== m_overrun) begin
        errors++;
        $display("FAIL mask step %0d: got v=%b idx=%0d pend=%h ovr=%b, expected v=%b idx=%0d pend=%h ovr=%b",
                 s, out_valid, out_index, pending, overrun, m_valid, m_index, m_pending, m_overrun);
      end
      if (s == 2 || s == 3) begin
        checks++;
        if (out_valid !== 1'b0 || pending !== 8'h80) begin
          errors++;
          $display("FAIL mask_hold step %0d: got v=%b pend=%h, expected v=0 pend=80", s, out_valid, pending);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd7) begin
      errors++;
      $display("FAIL mask_unmask_grant: got v=%b idx=%0d, expected v=1 idx=7", out_valid, out_index);
    end
  endtask

  task automatic test_same_edge();
    logic [7:0] ins  [7] = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h08};
    logic       acks [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int s = 0; s < 7; s++) begin
      drive(ins[s], 1'b0, 8'h00, acks[s]);
      step();
      checks++;
      if (out_valid !== m_valid || out_index !== 3'(m_index) || pending !== m_pending || overrun !== m_overrun) begin
        errors++;
        $display("FAIL same_edge step %0d: got v=%b idx=%0d pend=%h ovr=%b, expected v=%b idx=%0d pend=%h ovr=%b",
                 s, out_valid, out_index, pending, overrun, m_valid, m_index, m_pending, m_overrun);
      end
      if (s == 4) begin
        checks++;
        if (pending !== 8'h08 || overrun !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL same_edge_setwins: got pend=%h ovr=%b v=%b, expected pend=08 ovr=0 v=0",
                   pending, overrun, out_valid);
        end
      end
      if (s == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd3) begin
          errors++;
          $display("FAIL same_edge_regrant: got v=%b idx=%0d, expected v=1 idx=3", out_valid, out_index);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] ins  [10] = '{8'h00, 8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};
    logic       acks [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int grants;
    bit was_valid;
    grants = 0; was_valid = 1'b0;
    apply_reset();
    for (int s = 0; s < 10; s++) begin
      drive(ins[s], 1'b0, 8'h00, acks[s]);
      step();
      if (out_valid && !was_valid) grants++;
      was_valid = out_valid;
      checks++;
      if (out_valid !== m_valid || out_index !== 3'(m_index) || pending !== m_pending || overrun !== m_overrun) begin
        errors++;
        $display("FAIL overrun step %0d: got v=%b idx=%0d pend=%h ovr=%b, expected v=%b idx=%0d pend=%h ovr=%b",
                 s, out_valid, out_index, pending, overrun, m_valid, m_index, m_pending, m_overrun);
      end
    end
    checks++;
    if (overrun !== 1'b1 || grants != 1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky: got ovr=%b grants=%0d v=%b, expected ovr=1 grants=1 v=0",
               overrun, grants, out_valid);
    end
  endtask

  task automatic test_high_at_reset();
    logic [7:0] ins [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hFF, 8'hFF};
    in_lines = 8'hFF;
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      drive(ins[s], 1'b0, 8'h00, 1'b0);
      step();
      checks++;
      if (out_valid !== m_valid || out_index !== 3'(m_index) || pending !== m_pending || overrun !== m_overrun) begin
        errors++;
        $display("FAIL high_at_reset step %0d: got v=%b idx=%0d pend=%h ovr=%b, expected v=%b idx=%0d pend=%h ovr=%b",
                 s, out_valid, out_index, pending, overrun, m_valid, m_index, m_pending, m_overrun);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd6 || pending !== 8'h40) begin
      errors++;
      $display("FAIL high_at_reset_line6: got v=%b idx=%0d pend=%h, expected v=1 idx=6 pend=40",
               out_valid, out_index, pending);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] ins [3] = '{8'h00, 8'h0E, 8'h0E};
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      drive(ins[s], 1'b0, 8'h00, 1'b0);
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd3 || pending !== 8'h0E) begin
      errors++;
      $display("FAIL async_reset_setup: got v=%b idx=%0d pend=%h, expected v=1 idx=3 pend=0e",
               out_valid, out_index, pending);
    end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || out_index !== 3'd0) begin
      errors++;
      $display("FAIL async_reset_immediate: got v=%b idx=%0d pend=%h, expected v=0 idx=0 pend=00",
               out_valid, out_index, pending);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    in_lines = 8'h00;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) apply_reset();
      if ($urandom_range(0, 2) == 0) in_lines = in_lines ^ 8'($urandom);
      out_ack = 1'($urandom_range(0, 1));
      mask_we = ($urandom_range(0, 11) == 0);
      mask_in = 8'($urandom);
      step();
      checks++;
      if (out_valid !== m_valid || out_index !== 3'(m_index) || pending !== m_pending || overrun !== m_overrun) begin
        errors++;
        $display("FAIL random cycle %0d: got v=%b idx=%0d pend=%h ovr=%b, expected v=%b idx=%0d pend=%h ovr=%b",
                 c, out_valid, out_index, pending, overrun, m_valid, m_index, m_pending, m_overrun);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_two_lines();
    test_mask();
    test_same_edge();
    test_overrun();
    test_high_at_reset();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_event_encoder.md
PRIORITY_EVENT_ENCODER -- requirements
Module: priority_event_encoder

Interface
REQ-001 Parameter N_LINES, default 8: number of request lines; legal values 2..64.
REQ-002 Parameter IDX_WIDTH, default 3: output index width; SHALL equal ceil(log2(N_LINES)); elaboration error otherwise.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_lines  input  N_LINES  level request lines, synchronous to clk.
REQ-006 Port mask_we  input  1  mask write strobe.
REQ-007 Port mask_in  input  N_LINES  new mask value (1 = line enabled).
REQ-008 Port out_ack  input  1  consumer acknowledge of the presented index.
REQ-009 Port out_valid  output  1  out_index holds a granted event.
REQ-010 Port out_index  output  IDX_WIDTH  index of the granted line.
REQ-011 Port pending  output  N_LINES  current pending-event register.
REQ-012 Port overrun  output  1  sticky flag: an event was lost.

Function
REQ-013 Event detect: a line generates an event at a clock edge where in_lines[i]=1 and the registered previous sample in_prev[i]=0; in_prev updates from in_lines every cycle.
REQ-014 An event sets pending[i] at that same edge, regardless of mask.
REQ-015 Priority: highest index wins; candidates = pending & mask, excluding the line currently presented.
REQ-016 FSM has two states: IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-017 IDLE: if candidates is nonzero at an edge, out_index is loaded with the highest candidate index and the state becomes PRESENT at that edge; otherwise remain IDLE.
REQ-018 Latency: an event detected at edge t is presented, with out_valid=1, from edge t+1 if it is the highest candidate and the FSM is IDLE at t+1.
REQ-019 PRESENT: out_index and out_valid SHALL hold stable until an edge with out_ack=1.
REQ-020 Higher-priority events arriving in PRESENT do not preempt; they wait as pending.
REQ-021 Handshake: an edge in PRESENT with out_ack=1 clears pending[out_index] and returns the FSM to IDLE; out_valid=0 for at least one cycle between grants, so the maximum grant rate is one per 2 cycles.
REQ-022 out_ack while IDLE is ignored.
REQ-023 Simultaneous clear and new event on the same line at one edge: the set wins; pending stays 1 and the line is re-granted later.
REQ-024 Event on a line whose pending bit is already 1 (excluding the REQ-023 case) is lost and sets overrun=1; overrun clears only on reset.
REQ-025 mask_we=1 at an edge loads mask from mask_in; the new mask affects selection from the next edge.
REQ-026 A mask change never withdraws an index already presented; masked pending bits are retained and become eligible once unmasked.
REQ-027 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-028 While reset=1, independent of clk: out_valid=0, out_index=0, pending=0, overrun=0, mask=all ones, in_prev=all ones, FSM=IDLE.
REQ-029 in_prev=all ones means lines already high at reset release generate no event until they fall and rise again.
REQ-030 Reset asserted mid-grant (PRESENT) drops out_valid immediately and discards all pending events.

Verification (N_LINES=8)
REQ-031 Rising edges on lines 1 and 5 at the same edge -> out_index=5 valid next cycle; ack -> 1 cycle idle -> out_index=1; ack -> pending=0.
REQ-032 mask=8'h7F, edge on line 7 -> pending=8'h80 and no valid; write mask=8'hFF -> out_index=7 valid one cycle after the mask write edge.
REQ-033 Line 3 presented, second rise on line 3 at the ack edge -> pending[3] stays 1, overrun=0, line 3 re-granted after 1 idle cycle.
REQ-034 Line 2 pending and not acked, line 2 falls and rises again -> overrun=1, single grant of index 2; overrun stays 1 until reset.
REQ-035 in_lines=8'hFF held through reset release -> no events, out_valid stays 0; drop line 6 then raise it -> out_index=6.
REQ-036 Reset pulse asynchronous to clk while PRESENT with 3 pending bits -> out_valid=0 and pending=0 immediately, before the next clk edge.
